// File: rtl/rf_alu_controller.sv
// Multicycle FETCH/DECODE/EXEC/COMMIT sequencer for the RF_ALU datapath.
// Every output is a register; decode is combinational from the latched instruction register.
module rf_alu_controller #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [WIDTH-1:0]   instr_i,
  input  logic               instrValid_i,
  output logic               instrReady_o,
  input  logic [7:0]         PSR_i,
  output logic               regWrite_o,
  output logic               shiftOrALU_o,
  output logic               alusrca_o,
  output logic               alusrcb_o,
  output logic [3:0]         aluControl_o,
  output logic               shiftType_o,
  output logic [REGBITS-1:0] regAddress1_o,
  output logic [REGBITS-1:0] regAddress2_o,
  output logic [WIDTH-1:0]   immediate_o,
  output logic               jumpEN_o,
  output logic               jalEN_o,
  output logic               ALUselect_o,
  output logic               pcEn_o,
  output logic               illegal_o,
  output logic [15:0]        retired_o
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    COMMIT,
    TRAP
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   ir_q;
  logic               instrReady_q, regWrite_q, shiftOrAlu_q, aluSrcA_q, aluSrcB_q;
  logic               shiftType_q, jumpEn_q, jalEn_q, aluSelect_q, pcEn_q, illegal_q;
  logic [3:0]         aluControl_q;
  logic [REGBITS-1:0] regAddress1_q, regAddress2_q;
  logic [WIDTH-1:0]   immediate_q;
  logic [15:0]        retired_q;

  logic [3:0]       op, ext, cond, aluCode, aluOp;
  logic             aluHit, condTrue;
  logic             decLegal, decRegWrite, decShiftOrAlu, decAluSrcA, decAluSrcB;
  logic             decShiftType, decAluSelect, decJal, decJcond;
  logic [3:0]       decAluControl;
  logic [WIDTH-1:0] decImm;
  logic             unusedPsr;

  assign op        = ir_q[15:12];
  assign cond      = ir_q[11:8];
  assign ext       = ir_q[7:4];
  assign unusedPsr = ^{PSR_i[7:5], PSR_i[2:0]};

  // R-type selects its ALU op through ext, immediate forms reuse the same codes in op
  always_comb begin
    aluCode = (op == 4'b0000) ? ext : op;
    aluHit  = 1'b1;
    case (aluCode)
      4'b0101: aluOp = 4'b0000;
      4'b1001: aluOp = 4'b0001;
      4'b0001: aluOp = 4'b0010;
      4'b0010: aluOp = 4'b0011;
      4'b0011: aluOp = 4'b0100;
      4'b1011: aluOp = 4'b0101;
      4'b1101: aluOp = 4'b0110;
      default: begin
        aluOp  = 4'b0000;
        aluHit = 1'b0;
      end
    endcase
  end

  always_comb begin
    decLegal      = 1'b0;
    decRegWrite   = 1'b0;
    decShiftOrAlu = 1'b0;
    decAluSrcA    = 1'b0;
    decAluSrcB    = 1'b0;
    decAluControl = 4'b0000;
    decShiftType  = 1'b0;
    decAluSelect  = 1'b0;
    decJal        = 1'b0;
    decJcond      = 1'b0;
    decImm        = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
    case (op)
      4'b0000, 4'b0101, 4'b1001, 4'b0001, 4'b0010, 4'b0011, 4'b1011, 4'b1101: begin
        if (aluHit) begin
          decLegal      = 1'b1;
          decShiftOrAlu = 1'b1;
          decAluSrcA    = 1'b1;
          decAluSrcB    = (op != 4'b0000);
          decAluControl = aluOp;
          decRegWrite   = (aluOp != 4'b0101);
          if (op == 4'b0001 || op == 4'b0010 || op == 4'b0011) begin
            decImm = {{(WIDTH-8){1'b0}}, ir_q[7:0]};
          end
        end
      end
      4'b1000: begin
        if (ext == 4'b0100) begin
          decLegal    = 1'b1;
          decRegWrite = 1'b1;
        end else if (ext == 4'b0000 || ext == 4'b0001) begin
          decLegal     = 1'b1;
          decRegWrite  = 1'b1;
          decShiftType = 1'b1;
          decImm       = {{(WIDTH-4){ir_q[3]}}, ir_q[3:0]};
        end
      end
      4'b0100: begin
        if (ext == 4'b1000) begin
          decLegal     = 1'b1;
          decJal       = 1'b1;
          decAluSelect = 1'b1;
          decRegWrite  = 1'b1;
        end else if (ext == 4'b1100 && (cond == 4'b0000 || cond == 4'b0001 ||
                     cond == 4'b1101 || cond == 4'b1100 || cond == 4'b1110)) begin
          decLegal = 1'b1;
          decJcond = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Branch condition is evaluated from the live flags on the EXEC -> COMMIT edge
  always_comb begin
    case (cond)
      4'b0000: condTrue = PSR_i[3];
      4'b0001: condTrue = !PSR_i[3];
      4'b1101: condTrue = PSR_i[4] | PSR_i[3];
      4'b1100: condTrue = !PSR_i[4] && !PSR_i[3];
      4'b1110: condTrue = 1'b1;
      default: condTrue = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= FETCH;
      ir_q          <= '0;
      instrReady_q  <= 1'b0;
      regWrite_q    <= 1'b0;
      shiftOrAlu_q  <= 1'b0;
      aluSrcA_q     <= 1'b0;
      aluSrcB_q     <= 1'b0;
      aluControl_q  <= 4'b0000;
      shiftType_q   <= 1'b0;
      regAddress1_q <= '0;
      regAddress2_q <= '0;
      immediate_q   <= '0;
      jumpEn_q      <= 1'b0;
      jalEn_q       <= 1'b0;
      aluSelect_q   <= 1'b0;
      pcEn_q        <= 1'b0;
      illegal_q     <= 1'b0;
      retired_q     <= 16'd0;
    end else begin
      case (state_q)
        FETCH: begin
          if (instrValid_i && instrReady_q) begin
            ir_q         <= instr_i;
            instrReady_q <= 1'b0;
            state_q      <= DECODE;
          end else begin
            instrReady_q <= 1'b1;
          end
        end
        DECODE: begin
          if (decLegal) begin
            state_q       <= EXEC;
            shiftOrAlu_q  <= decShiftOrAlu;
            aluSrcA_q     <= decAluSrcA;
            aluSrcB_q     <= decAluSrcB;
            aluControl_q  <= decAluControl;
            shiftType_q   <= decShiftType;
            aluSelect_q   <= decAluSelect;
            regAddress1_q <= ir_q[8 +: REGBITS];
            regAddress2_q <= ir_q[0 +: REGBITS];
            immediate_q   <= decImm;
          end else begin
            state_q   <= TRAP;
            illegal_q <= 1'b1;
          end
        end
        // JAL keeps ALUselect through COMMIT so the link value is what gets written
        EXEC: begin
          state_q      <= COMMIT;
          shiftOrAlu_q <= 1'b0;
          aluSrcA_q    <= 1'b0;
          aluSrcB_q    <= 1'b0;
          aluControl_q <= 4'b0000;
          shiftType_q  <= 1'b0;
          aluSelect_q  <= decJal;
          regWrite_q   <= decRegWrite;
          pcEn_q       <= 1'b1;
          jumpEn_q     <= decJal | (decJcond & condTrue);
          jalEn_q      <= decJal;
          retired_q    <= retired_q + 16'd1;
        end
        COMMIT: begin
          state_q      <= FETCH;
          regWrite_q   <= 1'b0;
          pcEn_q       <= 1'b0;
          jumpEn_q     <= 1'b0;
          jalEn_q      <= 1'b0;
          aluSelect_q  <= 1'b0;
          instrReady_q <= 1'b1;
        end
        TRAP:    state_q <= TRAP;
        default: state_q <= TRAP;
      endcase
    end
  end

  assign instrReady_o  = instrReady_q;
  assign regWrite_o    = regWrite_q;
  assign shiftOrALU_o  = shiftOrAlu_q;
  assign alusrca_o     = aluSrcA_q;
  assign alusrcb_o     = aluSrcB_q;
  assign aluControl_o  = aluControl_q;
  assign shiftType_o   = shiftType_q;
  assign regAddress1_o = regAddress1_q;
  assign regAddress2_o = regAddress2_q;
  assign immediate_o   = immediate_q;
  assign jumpEN_o      = jumpEn_q;
  assign jalEN_o       = jalEn_q;
  assign ALUselect_o   = aluSelect_q;
  assign pcEn_o        = pcEn_q;
  assign illegal_o     = illegal_q;
  assign retired_o     = retired_q;

endmodule
